// File: rtl/sprite_anim.sv
// sprite_anim
// -----------
// Draws a WIDTH x HEIGHT sprite, integer-scaled by SCALE_X / SCALE_Y, from a
// synchronous graphics memory at a signed screen position. Each draw latches
// an animation frame and horizontal/vertical mirror controls. Pixels equal to
// the TRANSP colour index are reported as transparent.
//
// Handshake: there is no valid/ready pair. A draw begins on a line strobe
// whose sy matches spry while en is high and the block is idle. Once started,
// the draw always runs to completion; only rst stops it. The caller must keep
// the sprite horizontally inside the active area so that sx reaches
// sprx-LAT on every sprite line.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   line_i           start-of-line strobe from the timing generator
//   sx_i, sy_i       current screen position (signed)
//   sprx_i, spry_i   sprite top-left position (signed)
//   en_i             sprite enable, looked at only when a draw could start
//   frame_i          animation frame, latched at start, clamped to FRAMES-1
//   flip_x_i/_y_i    mirror controls, latched at start
//   data_in_i        memory read data
//   pos_o            memory address
//   pix_o            pixel colour, 0 when not drawing or transparent
//   opaque_o         drawing and data_in_i differs from TRANSP
//   drawing_o        a sprite pixel is being emitted this cycle
//   done_o           sprite finished for this frame
//   state_o          current FSM state, for debug and checkers
module sprite_anim #(
  parameter int WIDTH     = 8,
  parameter int HEIGHT    = 8,
  parameter int FRAMES    = 2,
  parameter int SCALE_X   = 1,
  parameter int SCALE_Y   = 1,
  parameter int COLR_BITS = 4,
  parameter int TRANSP    = 0,
  parameter int CORDW     = 16,
  parameter int ADDRW     = 7,
  parameter int LAT       = 2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         line_i,
  input  logic signed [CORDW-1:0]                      sx_i,
  input  logic signed [CORDW-1:0]                      sy_i,
  input  logic signed [CORDW-1:0]                      sprx_i,
  input  logic signed [CORDW-1:0]                      spry_i,
  input  logic                                         en_i,
  input  logic [((FRAMES > 1) ? $clog2(FRAMES) : 1)-1:0] frame_i,
  input  logic                                         flip_x_i,
  input  logic                                         flip_y_i,
  input  logic [COLR_BITS-1:0]                         data_in_i,
  output logic [ADDRW-1:0]                             pos_o,
  output logic [COLR_BITS-1:0]                         pix_o,
  output logic                                         opaque_o,
  output logic                                         drawing_o,
  output logic                                         done_o,
  output logic [2:0]                                   state_o
);

  localparam int FW  = (FRAMES > 1)  ? $clog2(FRAMES)  : 1;
  localparam int OXW = (WIDTH > 1)   ? $clog2(WIDTH)   : 1;
  localparam int OYW = (HEIGHT > 1)  ? $clog2(HEIGHT)  : 1;
  localparam int CXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int CYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    AWAIT_POS = 3'd2,
    DRAW      = 3'd3,
    NEXT_LINE = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t         state_q;
  logic [OXW-1:0] ox_q;
  logic [OYW-1:0] oy_q;
  logic [CXW-1:0] cnt_x_q;
  logic [CYW-1:0] cnt_y_q;
  logic [FW-1:0]  frame_q;
  logic           fx_q;
  logic           fy_q;
  logic           done_q;

  // Trigger column compared one bit wider so sprx-LAT cannot wrap around
  // when the sprite sits near the negative edge of the coordinate range.
  logic signed [CORDW:0] sx_ext;
  logic signed [CORDW:0] trig_x;
  assign sx_ext = {sx_i[CORDW-1], sx_i};
  assign trig_x = {sprx_i[CORDW-1], sprx_i} - (CORDW+1)'(LAT);

  logic last_pix;
  logic last_line;
  logic start_cond;
  assign last_pix   = (ox_q == OXW'(WIDTH - 1)) && (cnt_x_q == CXW'(SCALE_X - 1));
  assign last_line  = (oy_q == OYW'(HEIGHT - 1)) && (cnt_y_q == CYW'(SCALE_Y - 1));
  assign start_cond = line_i && (sy_i == spry_i) && en_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ox_q    <= '0;
      oy_q    <= '0;
      cnt_x_q <= '0;
      cnt_y_q <= '0;
      frame_q <= '0;
      fx_q    <= 1'b0;
      fy_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_cond) begin
            state_q <= START;
            frame_q <= (int'(frame_i) >= FRAMES) ? FW'(FRAMES - 1) : frame_i;
            fx_q    <= flip_x_i;
            fy_q    <= flip_y_i;
          end
        end
        START: begin
          done_q  <= 1'b0;
          oy_q    <= '0;
          cnt_y_q <= '0;
          state_q <= AWAIT_POS;
        end
        AWAIT_POS: begin
          ox_q    <= '0;
          cnt_x_q <= '0;
          if (sx_ext == trig_x) begin
            state_q <= DRAW;
          end
        end
        DRAW: begin
          if (last_pix) begin
            // Counters are left on the last pixel; AWAIT_POS re-clears them.
            state_q <= last_line ? DONE : NEXT_LINE;
          end else if (cnt_x_q == CXW'(SCALE_X - 1)) begin
            cnt_x_q <= '0;
            ox_q    <= ox_q + 1'b1;
          end else begin
            cnt_x_q <= cnt_x_q + 1'b1;
          end
        end
        NEXT_LINE: begin
          if (cnt_y_q == CYW'(SCALE_Y - 1)) begin
            cnt_y_q <= '0;
            oy_q    <= oy_q + 1'b1;
          end else begin
            cnt_y_q <= cnt_y_q + 1'b1;
          end
          state_q <= AWAIT_POS;
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Mirroring is applied to the source coordinates, so the address walks
  // backwards through a row (flip_x) or through the rows (flip_y).
  int col;
  int row;
  always_comb begin
    col   = fx_q ? (WIDTH - 1 - int'(ox_q)) : int'(ox_q);
    row   = fy_q ? (HEIGHT - 1 - int'(oy_q)) : int'(oy_q);
    pos_o = ADDRW'(int'(frame_q) * WIDTH * HEIGHT + row * WIDTH + col);
  end

  assign drawing_o = (state_q == DRAW);
  assign opaque_o  = drawing_o && (data_in_i != COLR_BITS'(TRANSP));
  assign pix_o     = opaque_o ? data_in_i : '0;
  assign done_o    = done_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_sprite_anim.sv
// Bench for sprite_anim. Two instances share all inputs: instance 0 is the
// plain 8x8 renderer (scale 1, two frames), instance 1 is scaled 2x3 with
// three frames. A small line-based model predicts every output each cycle;
// a table of sprite setups adds per-draw expectations (cycle counts, first
// and last address).
module tb_sprite_anim;

  localparam int W      = 8;
  localparam int H      = 8;
  localparam int LAT    = 2;
  localparam int TRANSP = 0;
  localparam int SX_MIN = -16;
  localparam int SX_MAX = 119;
  localparam int NONE   = 9999;

  // clock / reset / inputs
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               line_i;
  logic signed [15:0] sx_i, sy_i, sprx_i, spry_i;
  logic               en_i;
  logic [1:0]         frame_i;
  logic               flip_x_i, flip_y_i;
  logic [3:0]         data_in_i;

  logic [6:0] pos_a;
  logic [7:0] pos_b;
  logic [3:0] pix_a, pix_b;
  logic       opaque_a, opaque_b, drawing_a, drawing_b, done_a, done_b;
  logic [2:0] state_a, state_b;

  sprite_anim #(.WIDTH(W), .HEIGHT(H), .FRAMES(2), .SCALE_X(1), .SCALE_Y(1),
                .COLR_BITS(4), .TRANSP(TRANSP), .CORDW(16), .ADDRW(7), .LAT(LAT)) u_a (
    .clk(clk), .rst(rst), .line_i(line_i), .sx_i(sx_i), .sy_i(sy_i),
    .sprx_i(sprx_i), .spry_i(spry_i), .en_i(en_i), .frame_i(frame_i[0:0]),
    .flip_x_i(flip_x_i), .flip_y_i(flip_y_i), .data_in_i(data_in_i),
    .pos_o(pos_a), .pix_o(pix_a), .opaque_o(opaque_a), .drawing_o(drawing_a),
    .done_o(done_a), .state_o(state_a));

  sprite_anim #(.WIDTH(W), .HEIGHT(H), .FRAMES(3), .SCALE_X(2), .SCALE_Y(3),
                .COLR_BITS(4), .TRANSP(TRANSP), .CORDW(16), .ADDRW(8), .LAT(LAT)) u_b (
    .clk(clk), .rst(rst), .line_i(line_i), .sx_i(sx_i), .sy_i(sy_i),
    .sprx_i(sprx_i), .spry_i(spry_i), .en_i(en_i), .frame_i(frame_i),
    .flip_x_i(flip_x_i), .flip_y_i(flip_y_i), .data_in_i(data_in_i),
    .pos_o(pos_b), .pix_o(pix_b), .opaque_o(opaque_b), .drawing_o(drawing_b),
    .done_o(done_b), .state_o(state_b));

  function automatic int scx(input int i); return (i == 0) ? 1 : 2; endfunction
  function automatic int scy(input int i); return (i == 0) ? 1 : 3; endfunction
  function automatic int nfr(input int i); return (i == 0) ? 2 : 3; endfunction
  function automatic int awd(input int i); return (i == 0) ? 7 : 8; endfunction

  // scoreboard counters
  int checks;
  int errors;
  int cur_x, cur_y, cur_sprx;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (sy=%0d sx=%0d t=%0t)",
               name, act, exp, cur_y, cur_x, $time);
    end
  endtask

  // Reference model: a draw is a sequence of screen lines k = 0 .. H*SY-1,
  // each covering a window of W*SX columns starting one column after
  // sprx-LAT. Source row = k/SY, source column = offset/SX.
  bit m_valid;
  bit m_active[2];
  int m_k[2];
  int m_f[2];
  bit m_fx[2], m_fy[2];
  bit m_done[2];
  int m_clr[2];
  bit m_fresh[2];

  int draw_cnt[2], base_cnt[2], first_pos[2], last_pos[2];

  task automatic check_cycle();
    int a, span, ox, oy, c, r, ep;
    bit ed, eo;
    int epix;
    int act_d, act_o, act_p, act_dn, act_pos;
    for (int i = 0; i < 2; i++) begin
      act_d   = (i == 0) ? int'(drawing_a) : int'(drawing_b);
      act_o   = (i == 0) ? int'(opaque_a)  : int'(opaque_b);
      act_p   = (i == 0) ? int'(pix_a)     : int'(pix_b);
      act_dn  = (i == 0) ? int'(done_a)    : int'(done_b);
      act_pos = (i == 0) ? int'(pos_a)     : int'(pos_b);
      if (act_d != 0) begin
        if (draw_cnt[i] == base_cnt[i]) first_pos[i] = act_pos;
        last_pos[i] = act_pos;
        draw_cnt[i]++;
      end
      if (m_valid) begin
        a    = cur_sprx - LAT;
        span = W * scx(i);
        if (m_clr[i] > 0) begin
          m_clr[i]--;
          if (m_clr[i] == 0) m_done[i] = 1'b0;
        end
        if (m_active[i] && m_k[i] == H * scy(i) - 1 && cur_x == a + span + 2) begin
          m_active[i] = 1'b0;
          m_done[i]   = 1'b1;
        end
        ed   = m_active[i] && (cur_x >= a + 1) && (cur_x <= a + span);
        eo   = ed && (int'(data_in_i) != TRANSP);
        epix = eo ? int'(data_in_i) : 0;
        chk((i == 0) ? "a drawing" : "b drawing", act_d, int'(ed));
        chk((i == 0) ? "a opaque" : "b opaque", act_o, int'(eo));
        chk((i == 0) ? "a pix" : "b pix", act_p, epix);
        chk((i == 0) ? "a done" : "b done", act_dn, int'(m_done[i]));
        if (ed) begin
          ox = (cur_x - (a + 1)) / scx(i);
          oy = m_k[i] / scy(i);
          c  = m_fx[i] ? (W - 1 - ox) : ox;
          r  = m_fy[i] ? (H - 1 - oy) : oy;
          ep = (m_f[i] * W * H + r * W + c) % (1 << awd(i));
          chk((i == 0) ? "a pos" : "b pos", act_pos, ep);
        end else if (m_fresh[i]) begin
          chk((i == 0) ? "a pos after reset" : "b pos after reset", act_pos, 0);
        end
      end
    end
  endtask

  task automatic model_update();
    int fr;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_active[i] = 1'b0;
        m_done[i]   = 1'b0;
        m_clr[i]    = 0;
        m_k[i]      = 0;
        m_fresh[i]  = 1'b1;
      end else if (m_active[i]) begin
        if (line_i) m_k[i]++;
      end else if (line_i && cur_y == int'(spry_i) && en_i) begin
        fr          = (i == 0) ? int'(frame_i[0]) : int'(frame_i);
        m_f[i]      = (fr > nfr(i) - 1) ? nfr(i) - 1 : fr;
        m_fx[i]     = flip_x_i;
        m_fy[i]     = flip_y_i;
        m_active[i] = 1'b1;
        m_k[i]      = 0;
        m_clr[i]    = 2;
        m_fresh[i]  = 1'b0;
      end
    end
    if (rst) m_valid = 1'b1;
  endtask

  // driver tasks
  task automatic tick(input bit do_rst);
    rst       = do_rst;
    data_in_i = ($urandom_range(0, 3) == 0) ? 4'(TRANSP) : 4'($urandom_range(0, 15));
    @(negedge clk);
    check_cycle();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic run_line(input int y, input int rst_sx);
    for (int x = SX_MIN; x <= SX_MAX; x++) begin
      cur_x  = x;
      cur_y  = y;
      sx_i   = 16'(x);
      sy_i   = 16'(y);
      line_i = (x == SX_MIN);
      tick(x == rst_sx);
    end
  endtask

  task automatic set_sprite(input int px, input int py, input bit en,
                            input int fr, input bit fx, input bit fy);
    cur_sprx = px;
    sprx_i   = 16'(px);
    spry_i   = 16'(py);
    en_i     = en;
    frame_i  = 2'(fr);
    flip_x_i = fx;
    flip_y_i = fy;
  endtask

  typedef struct {
    int sprx; int spry; bit en; int frame; bit fx; bit fy; bit en_drop; bit chk_pos;
    int cnt_a; int first_a; int last_a;
    int cnt_b; int first_b; int last_b;
  } vec_t;

  vec_t tbl[6];

  task automatic run_entry(input vec_t e);
    set_sprite(e.sprx, e.spry, e.en, e.frame, e.fx, e.fy);
    base_cnt[0] = draw_cnt[0];
    base_cnt[1] = draw_cnt[1];
    for (int l = 0; l < 28; l++) begin
      if (e.en_drop && l == 3) en_i = 1'b0;
      run_line(e.spry - 2 + l, NONE);
    end
    chk("a draw cycles", draw_cnt[0] - base_cnt[0], e.cnt_a);
    chk("b draw cycles", draw_cnt[1] - base_cnt[1], e.cnt_b);
    if (e.chk_pos) begin
      chk("a first pos", first_pos[0], e.first_a);
      chk("a last pos", last_pos[0], e.last_a);
      chk("b first pos", first_pos[1], e.first_b);
      chk("b last pos", last_pos[1], e.last_b);
    end
  endtask

  initial begin
    vec_t rv;
    checks  = 0;
    errors  = 0;
    m_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0; m_k[i] = 0; m_f[i] = 0; m_fx[i] = 0; m_fy[i] = 0;
      m_done[i] = 0; m_clr[i] = 0; m_fresh[i] = 0;
      draw_cnt[i] = 0; base_cnt[i] = 0; first_pos[i] = 0; last_pos[i] = 0;
    end
    //            sprx spry en fr fx fy drop pos | cnt first last (a) | cnt first last (b)
    tbl[0] = '{100, 50, 1, 0, 0, 0, 0, 1,  64,   0,  63,  384,   0,  63};
    tbl[1] = '{ 40, 10, 1, 1, 1, 1, 0, 1,  64, 127,  64,  384, 127,  64};
    tbl[2] = '{ 20, 30, 1, 3, 0, 0, 0, 1,  64,  64, 127,  384, 128, 191};
    tbl[3] = '{ 70, 15, 0, 1, 0, 0, 0, 0,   0,   0,   0,    0,   0,   0};
    tbl[4] = '{ -5,  3, 1, 2, 1, 0, 0, 1,  64,   7,  56,  384, 135, 184};
    tbl[5] = '{ 60, 20, 1, 1, 0, 1, 1, 1,  64, 120,  71,  384, 120,  71};

    cur_x = SX_MIN; cur_y = 0; line_i = 1'b0;
    sx_i = 16'(SX_MIN); sy_i = '0;
    set_sprite(0, 200, 1'b0, 0, 1'b0, 1'b0);
    repeat (3) tick(1'b1);
    run_line(0, NONE);

    for (int t = 0; t < 6; t++) run_entry(tbl[t]);

    // sy held at spry: a start seen mid-draw must be ignored, and a new
    // draw starts on the first strobe after the block returns to idle.
    set_sprite(30, 5, 1'b1, 0, 1'b0, 1'b0);
    base_cnt[0] = draw_cnt[0];
    base_cnt[1] = draw_cnt[1];
    for (int l = 0; l < 30; l++) run_line(5, NONE);
    chk("a cycles sy stuck", draw_cnt[0] - base_cnt[0], 240);
    chk("b cycles sy stuck", draw_cnt[1] - base_cnt[1], 480);

    // reset pulsed in the middle of sprite line 3
    set_sprite(50, 12, 1'b1, 1, 1'b1, 1'b0);
    for (int y = 10; y < 15; y++) run_line(y, NONE);
    run_line(15, 50);
    chk("a done after reset", int'(done_a), 0);
    chk("b done after reset", int'(done_b), 0);
    for (int y = 16; y < 18; y++) run_line(y, NONE);

    // clean restart after the abandoned draw
    run_entry(tbl[0]);

    for (int n = 0; n < 3; n++) begin
      rv.sprx    = int'($urandom_range(0, 110)) - 10;
      rv.spry    = int'($urandom_range(0, 80)) - 20;
      rv.en      = ($urandom_range(0, 3) != 0);
      rv.frame   = int'($urandom_range(0, 3));
      rv.fx      = 1'($urandom_range(0, 1));
      rv.fy      = 1'($urandom_range(0, 1));
      rv.en_drop = 1'($urandom_range(0, 1));
      rv.chk_pos = 1'b0;
      rv.cnt_a   = rv.en ? W * H : 0;
      rv.cnt_b   = rv.en ? W * H * 2 * 3 : 0;
      rv.first_a = 0; rv.last_a = 0; rv.first_b = 0; rv.last_b = 0;
      run_entry(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_anim.md
# sprite_anim

Scaled, animated sprite renderer for the scanline pipeline: draws a WIDTH×HEIGHT sprite from external graphics memory at a signed screen position. Adds multi-frame animation, per-draw horizontal/vertical mirroring, a transparent colour key and an enable gate on top of the basic integer-scaled renderer. It sits between the display timing generator (sx, sy, line) and a synchronous sprite ROM/BRAM. The output pixel feeds the layer compositor.

## Interface
- WIDTH, 8: sprite width in pixels
- HEIGHT, 8: sprite height in pixels
- FRAMES, 2: animation frames stored back-to-back in memory
- SCALE_X, 1: horizontal scale factor (≥1)
- SCALE_Y, 1: vertical scale factor (≥1)
- COLR_BITS, 4: bits per pixel
- TRANSP, 0: colour index treated as transparent
- CORDW, 16: signed screen coordinate width
- ADDRW, 7: memory address width, ≥ clog2(WIDTH·HEIGHT·FRAMES)
- LAT, 2: pixels of lead before sprx at which drawing begins (memory latency)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- line  in  1  start-of-line strobe
- sx, sy  in  CORDW signed  current screen position
- sprx, spry  in  CORDW signed  sprite top-left position
- en  in  1  sprite enable, sampled only at start
- frame  in  clog2(FRAMES)  animation frame, latched at start
- flip_x, flip_y  in  1  mirror controls, latched at start
- data_in  in  COLR_BITS  memory read data
- pos  out  ADDRW  memory address
- pix  out  COLR_BITS  pixel colour, 0 when not drawing or transparent
- opaque  out  1  drawing and data_in ≠ TRANSP
- drawing  out  1  state is DRAW
- done  out  1  sprite complete for this frame

## Operation
- States: IDLE, START, AWAIT_POS, DRAW, NEXT_LINE, DONE.
- IDLE→START when line && sy==spry && en. Otherwise remain in IDLE. en low never aborts a draw in progress.
- Transition into START latches frame, flip_x and flip_y. A frame ≥ FRAMES is clamped to FRAMES-1.
- START: clear done, oy, cnt_y. →AWAIT_POS.
- AWAIT_POS: clear ox, cnt_x. →DRAW when sx == sprx-LAT (signed compare, CORDW+1-bit intermediate).
- DRAW: cnt_x counts 0..SCALE_X-1. At wrap, ox increments.
- DRAW exit: last pixel is ox==WIDTH-1 && cnt_x==SCALE_X-1. Exit to NEXT_LINE if not last line, else to DONE.
- NEXT_LINE: cnt_y counts 0..SCALE_Y-1. At wrap, oy increments. →AWAIT_POS.
- Last line is oy==HEIGHT-1 && cnt_y==SCALE_Y-1.
- DONE: set done. →IDLE.
- Address: pos = f·WIDTH·HEIGHT + r·WIDTH + c.
  - c = flip_x ? WIDTH-1-ox : ox
  - r = flip_y ? HEIGHT-1-oy : oy
  - Computed combinationally from registered counters and latched controls. Truncated to ADDRW.
- pix = (drawing && data_in≠TRANSP) ? data_in : 0. opaque follows the same condition.
- Reset: state IDLE, all counters 0, latched frame/flips 0, done 0.
  - Hence pos=0, pix=0, opaque=0, drawing=0 in the cycle after rst.
  - Reset mid-draw abandons the sprite. No done is produced.

## Timing
- One state transition per clk. All state, counters and done are registered. pos, pix, opaque and drawing are combinational from registers/data_in.
- First DRAW cycle occurs the clock after sx==sprx-LAT is sampled. Each sprite row spans exactly WIDTH·SCALE_X consecutive DRAW cycles.
- pos holds each source pixel for SCALE_X cycles. Each source row repeats for SCALE_Y screen lines.
- done rises the cycle after DONE. It stays high until the cycle after the next START.
- A start condition seen while not in IDLE is ignored.
- If sprx-LAT is never reached on a line (off-screen), the block waits in AWAIT_POS across lines. Caller constraint: the sprite lies fully within the active area horizontally.
- Total rows drawn: HEIGHT·SCALE_Y, starting on line spry.

## Test plan
- Basic draw: 8×8, scale 1, frame 0, no flips, sprx=100, spry=50, LAT=2 → DRAW entered the cycle after sx=98. pos runs 0..7 on line 50 and 56..63 on line 57. done rises after the last pixel.
- Scaling: SCALE_X=2, SCALE_Y=3 → each pos is held 2 cycles (16 DRAW cycles/line). Row-0 addresses 0..7 repeat on 3 lines. 24 lines drawn in total.
- Flip and frame: frame=1, flip_x=1, flip_y=1 → first line pos = 127,126,…,120. Last line pos = 71..64.
- Frame clamp and enable: frame=3 with FRAMES=2 → addresses come from frame 1. en=0 at the start line → stays IDLE, drawing never asserts.
- Transparency: data_in=TRANSP during DRAW → pix=0, opaque=0. data_in=5 → pix=5, opaque=1. Outside DRAW, pix=0 for any data_in.
- Reset mid-draw: rst pulsed during line 3 of the sprite → next cycle IDLE, pos=0, drawing=0, done=0. The next line with sy==spry restarts a clean draw.
